// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC and issues one word read at
// a time over a req/ack handshake. Returned words are buffered with their PCs
// in a small FIFO, and the head entry is presented to decode each cycle.
// A redirect flushes the buffer and restarts fetch at the new aligned PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] pc
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      buf_pc_q    [BUF_DEPTH];
  logic [31:0]      buf_pc_d    [BUF_DEPTH];
  logic [31:0]      buf_instr_q [BUF_DEPTH];
  logic [31:0]      buf_instr_d [BUF_DEPTH];

  logic push;
  logic pop;
  logic [1:0] unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc[1:0];

  // Request only while there is room; the address is the fetch PC, which
  // cannot change until the ack, so it stays stable across wait states.
  assign imem_req  = !rst && !redirect && (count_q < DEPTH_C);
  assign imem_addr = pc_q;
  assign pc        = rst ? RESET_PC : pc_q;

  assign if_valid  = !rst && (count_q != '0);
  assign if_pc     = if_valid ? buf_pc_q[rd_ptr_q]    : '0;
  assign if_instr  = if_valid ? buf_instr_q[rd_ptr_q] : '0;

  // Redirect suppresses the pop so the head is never counted as consumed.
  assign push = imem_req && imem_ack;
  assign pop  = if_valid && !stall && !redirect;

  // Next-state: redirect flushes and reloads the PC, otherwise push/pop.
  always_comb begin
    pc_d        = pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    if (redirect) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        buf_pc_d[wr_ptr_q]    = pc_q;
        buf_instr_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        pc_d                  = pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are only observable through a valid count.
  always_ff @(posedge clk) begin
    buf_pc_q    <= buf_pc_d;
    buf_instr_q <= buf_instr_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, wait states, stall fill,
// redirect with discard, PC wrap and mid-operation reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] pc;

  int unsigned passed = 0;
  int unsigned total  = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .pc(pc)
  );

  always #5 clk = ~clk;

  // Memory contents: each word is its address XOR 0xDEAD0000.
  assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    #1;
    // Reset held for two edges
    tick;
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_ifpc",  if_pc,    32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc",    pc,       32'd0);
    tick;
    chk("rst2_req",  {31'd0, imem_req}, 32'd0);
    chk("rst2_pc",   pc,       32'd0);

    // Streaming with ack tied high
    rst = 1'b0; imem_ack = 1'b1; #1;
    chk("s0_req",   {31'd0, imem_req}, 32'd1);
    chk("s0_addr",  imem_addr, 32'd0);
    chk("s0_valid", {31'd0, if_valid}, 32'd0);
    tick;
    chk("s1_valid", {31'd0, if_valid}, 32'd1);
    chk("s1_ifpc",  if_pc,    32'h0000_0000);
    chk("s1_instr", if_instr, 32'hDEAD_0000);
    chk("s1_pc",    pc,       32'h0000_0004);
    tick;
    chk("s2_ifpc",  if_pc,    32'h0000_0004);
    chk("s2_instr", if_instr, 32'hDEAD_0004);
    tick;
    chk("s3_ifpc",  if_pc,    32'h0000_0008);
    chk("s3_instr", if_instr, 32'hDEAD_0008);
    tick;
    chk("s4_valid", {31'd0, if_valid}, 32'd1);
    chk("s4_ifpc",  if_pc,    32'h0000_000C);
    chk("s4_instr", if_instr, 32'hDEAD_000C);

    // Wait states: ack on every third cycle
    rst = 1'b1; imem_ack = 1'b0;
    tick;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      imem_ack = ((k % 3) == 2);
      #1;
      if (k < 9) chk("ws_addr", imem_addr, 32'(4 * (k / 3)));
      chk("ws_valid", {31'd0, if_valid}, ((k % 3) == 0 && k > 0) ? 32'd1 : 32'd0);
      if ((k % 3) == 0 && k > 0) chk("ws_ifpc", if_pc, 32'(4 * (k / 3 - 1)));
      tick;
    end

    // Stall fill: two entries buffered, request drops when full
    rst = 1'b1; imem_ack = 1'b0;
    tick;
    rst = 1'b0; stall = 1'b1; imem_ack = 1'b1; #1;
    chk("sf0_req",   {31'd0, imem_req}, 32'd1);
    chk("sf0_valid", {31'd0, if_valid}, 32'd0);
    tick;
    chk("sf1_ifpc", if_pc,     32'h0000_0000);
    chk("sf1_req",  {31'd0, imem_req}, 32'd1);
    chk("sf1_addr", imem_addr, 32'h0000_0004);
    for (int k = 2; k < 5; k++) begin
      tick;
      chk("sf_full_req",   {31'd0, imem_req}, 32'd0);
      chk("sf_full_valid", {31'd0, if_valid}, 32'd1);
      chk("sf_full_ifpc",  if_pc, 32'h0000_0000);
      chk("sf_full_pc",    pc,    32'h0000_0008);
    end
    tick;
    stall = 1'b0; #1;
    chk("dr0_ifpc", if_pc, 32'h0000_0000);
    chk("dr0_req",  {31'd0, imem_req}, 32'd0);
    tick;
    chk("dr1_ifpc", if_pc,     32'h0000_0004);
    chk("dr1_req",  {31'd0, imem_req}, 32'd1);
    chk("dr1_addr", imem_addr, 32'h0000_0008);
    tick;
    chk("dr2_ifpc",  if_pc,    32'h0000_0008);
    chk("dr2_instr", if_instr, 32'hDEAD_0008);

    // Refill to full, then redirect with a concurrent ack
    stall = 1'b1;
    tick;
    chk("rd_full_req", {31'd0, imem_req}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0103; #1;
    chk("rd_req_low", {31'd0, imem_req}, 32'd0);
    tick;
    redirect = 1'b0; stall = 1'b0; #1;
    chk("rd1_valid", {31'd0, if_valid}, 32'd0);
    chk("rd1_req",   {31'd0, imem_req}, 32'd1);
    chk("rd1_addr",  imem_addr, 32'h0000_0100);
    tick;
    chk("rd2_ifpc",  if_pc,    32'h0000_0100);
    chk("rd2_instr", if_instr, 32'hDEAD_0100);
    tick;
    chk("rd3_ifpc",  if_pc,    32'h0000_0104);

    // PC wrap through redirect to the last word
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick;
    redirect = 1'b0; #1;
    chk("wr1_valid", {31'd0, if_valid}, 32'd0);
    chk("wr1_addr",  imem_addr, 32'hFFFF_FFFC);
    tick;
    chk("wr2_ifpc",  if_pc,     32'hFFFF_FFFC);
    chk("wr2_instr", if_instr,  32'h2152_FFFC);
    chk("wr2_addr",  imem_addr, 32'h0000_0000);
    chk("wr2_pc",    pc,        32'h0000_0000);
    tick;
    chk("wr3_ifpc",  if_pc,    32'h0000_0000);
    chk("wr3_instr", if_instr, 32'hDEAD_0000);

    // Mid-operation reset with two entries buffered
    stall = 1'b1;
    tick;
    chk("mr_full_req", {31'd0, imem_req}, 32'd0);
    chk("mr_full_pc",  pc, 32'h0000_0008);
    rst = 1'b1;
    tick;
    rst = 1'b0; stall = 1'b0; #1;
    chk("mr_valid", {31'd0, if_valid}, 32'd0);
    chk("mr_pc",    pc,        32'h0000_0000);
    chk("mr_addr",  imem_addr, 32'h0000_0000);
    chk("mr_req",   {31'd0, imem_req}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end that sits directly upstream of the `full_path` datapath. It owns the fetch program counter, issues word reads to instruction memory over a request/acknowledge handshake, and buffers returned instructions with their PCs in a small FIFO. It also presents one instruction per cycle to the decode side, honouring a decode stall and a branch/jump redirect.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch PC loaded on reset
- `BUF_DEPTH`, 2, instruction FIFO entries; power of two, ≥2
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  32  byte address of requested word, always 4-aligned
- `imem_ack`  in  1  memory completes the current request this cycle
- `imem_rdata`  in  32  instruction word, valid when `imem_ack`=1
- `redirect`  in  1  taken branch/jump: flush and refetch
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored
- `stall`  in  1  decode cannot accept the head instruction this cycle
- `if_valid`  out  1  head FIFO entry valid
- `if_pc`  out  32  PC of head entry
- `if_instr`  out  32  instruction of head entry
- `pc`  out  32  current fetch PC (next address to request)

## Operation
- Clock is `clk`; reset is `rst`, synchronous and active-high. No other clocks or async inputs.
- State: fetch PC register, FIFO storage (`BUF_DEPTH` × {pc[31:0], instr[31:0]}), read/write pointers, occupancy count (0..`BUF_DEPTH`).
- Request: `imem_req` = !`rst` && !`redirect` && count < `BUF_DEPTH`. `imem_addr` = fetch PC. At most one request outstanding; the address is held stable until acked.
- Accept: `imem_ack` is meaningful only while `imem_req`=1; ack with req=0 is ignored. On an accepted ack, push {fetch PC, `imem_rdata`} and set fetch PC += 4 (32-bit, wraps 32'hFFFF_FFFC → 0).
- Pop: occurs when `if_valid`=1 and `stall`=0, advancing the read pointer.
- Outputs: `if_valid` = (count != 0). `if_pc`/`if_instr` = head entry when valid; forced to 0 when empty.
- Simultaneous push and pop: count unchanged; both pointers advance. Push into full FIFO is impossible (req low when full). Pop from empty is a no-op.
- Redirect has priority over everything in its cycle:
  - count ← 0 and pointers ← 0.
  - fetch PC ← {`redirect_pc`[31:2], 2'b00}.
  - `imem_req`=0, so any ack that cycle is discarded.
  - The current head is treated as not consumed, regardless of `stall`.
- Stall only blocks pops; fetch continues until the FIFO is full.

## Timing
- Reset: while `rst`=1 at an edge, fetch PC ← `RESET_PC` and count ← 0. During the reset cycle `imem_req`=0, `if_valid`=0, `if_pc`=0, `if_instr`=0, `pc`=`RESET_PC`. Reset asserted mid-operation discards all buffered entries and any in-flight request.
- First `imem_req`=1 occurs in the first cycle with `rst`=0.
- Fetch latency: ack in cycle N → entry visible (`if_valid`=1) in cycle N+1. `pc` shows +4 in N+1.
- Throughput: with `imem_ack` tied high and `stall`=0, one instruction per cycle with no bubbles after the first.
- Redirect in cycle N → `imem_req`=1 with `imem_addr`=new PC in N+1; `if_valid`=0 in N+1.
- Wait states: each cycle of req=1/ack=0 holds `imem_addr` and adds one cycle of latency.

## Test plan
- Reset: hold `rst` 2 cycles with `RESET_PC`=0 → outputs zero, `pc`=0. Release → req with addr 0; with ack tied high, `if_pc` = 0, 4, 8, 12 on consecutive cycles, with `if_instr` matching memory.
- Wait states: ack every third cycle → `imem_addr` stable across waits; `if_valid` pulses with PCs 0, 4, 8 in order; no duplicates or drops.
- Stall fill: `stall`=1 for 5 cycles with ack high → exactly 2 entries buffered, `imem_req`=0 once full, `if_pc` held at 0. Release → drains 0, 4, then fetch of 8 resumes.
- Redirect: at full FIFO plus concurrent ack, `redirect`=1 with `redirect_pc`=32'h0000_0103 → next cycle `if_valid`=0, `imem_addr`=32'h0000_0100, and the acked word is discarded. Following outputs are 0x100, 0x104.
- Simultaneous push/pop at count=1 → count stays 1 and order is preserved. Wrap: `redirect_pc`=32'hFFFF_FFFC → subsequent fetch addr 0.
- Mid-operation reset with 2 entries buffered → next cycle `if_valid`=0, `pc`=`RESET_PC`.
